final_nios_pio_in_debounced: RTL and testbench
==============================================

// Module: final_nios_pio_in_debounced
// PURPOSE
//  Parametrised Avalon-MM input PIO for the Nios II system: next generation of the plain key/switch input port.
//  Adds per-bit synchroniser, per-bit debounce, an edge-capture register with write-1-to-clear, and a maskable level IRQ.
//  Sits between board pushbuttons/switches and the Avalon interconnect; one instance per input group.
// PARAMETERS
//  WIDTH           3      number of input bits (1..32)
//  SYNC_STAGES     2      synchroniser flops per bit (2..4)
//  DEBOUNCE_CYCLES 50000  consecutive clocks a new level must persist before acceptance (1..2^20)
//  EDGE_TYPE       0      0 = rising, 1 = falling, 2 = any edge sets edgecapture
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  address    in   2      register word select
//  chipselect in   1      Avalon slave select
//  write_n    in   1      Avalon write strobe, active-low
//  writedata  in   32     write data
//  in_port    in   WIDTH  asynchronous external inputs
//  readdata   out  32     registered read data
//  irq        out  1      level interrupt to the Nios II
// BEHAVIOUR
//  Reset (async, reset_n = 0):
//   - Cleared: all sync flops, stable[], debounce counters, irqmask, edgecapture, readdata, irq.
//  Register map:
//   - 0 = stable[WIDTH-1:0] (RO)
//   - 1 = reads 0
//   - 2 = irqmask (RW)
//   - 3 = edgecapture (R, W1C)
//   - Upper bits read 0.
//   - Writes to 0/1 ignored.
//  Write:
//   - Occurs on a clock edge with chipselect = 1 and write_n = 0.
//   - irqmask <= writedata[WIDTH-1:0].
//  Read:
//   - readdata <= zero-extended mux(address) on every clock edge; no side effects.
//   - Latency 1 clock.
//  Synchroniser:
//   - sync[b] = in_port[b] delayed SYNC_STAGES edges.
//  Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES):
//   - sync == stable: counter <= 0.
//   - sync != stable and counter < D-1: counter++.
//   - sync != stable and counter == D-1: stable <= sync, counter <= 0.
//   - A mismatch shorter than D consecutive samples is discarded.
//   - Any return to the stable level restarts the count.
//  Timing:
//   - in_port change registered at edge 1 -> stable changes at edge SYNC_STAGES + D.
//   - readdata shows it one edge later.
//  Edge capture:
//   - Set on the same edge stable[b] changes, if the transition matches EDGE_TYPE.
//   - Bits stay set until cleared by a write of 1 to addr 3.
//   - Set and W1C on the same bit in the same cycle: set wins.
//  IRQ:
//   - irq = |(edgecapture & irqmask), registered; asserts one edge after the edgecapture bit / mask bit becomes 1.
//   - Deasserts one edge after the clear.
//  Reset mid-debounce:
//   - Counters and stable clear; an in-flight transition is lost.
//   - An input held high across reset is re-accepted SYNC_STAGES + D edges after release (produces a rising edge).
// TESTING
//  - Reset, in_port = 0 -> readdata = 0 and irq = 0 at every address; addr 1 returns 0 after writing 0xFFFFFFFF.
//  - D = 4, S = 2; in_port[0] 0->1 held -> stable[0] = 1 exactly at edge 6; edgecapture = 0x1 on the same edge.
//  - D = 4: 3-cycle glitch on in_port[1] -> stable and edgecapture unchanged; counter back to 0.
//  - irqmask = 0x1, press bit0 -> irq = 1 one edge after capture.
//    W1C 0x1 to addr 3 -> edgecapture = 0, irq = 0 next edge.
//    Bit2 press with mask 0x1 -> irq stays 0.
//  - W1C bit0 written in the same cycle bit0 is re-captured -> edgecapture[0] = 1.
//  - EDGE_TYPE = 1: press (0->1) -> no capture; release (1->0) -> capture.
//    EDGE_TYPE = 2: both transitions capture.

Source files
------------

// File: rtl/final_nios_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// final_nios_pio_in_debounced
//   Avalon-MM input PIO with per-bit synchroniser and debounce, an edge-capture
//   register (write-1-to-clear) and a maskable, registered level interrupt.
//
//   Ports
//     clk, reset_n          system clock, asynchronous active-low reset
//     address[1:0]          register select: 0 stable, 1 zero, 2 irqmask,
//                           3 edgecapture (W1C)
//     chipselect, write_n   Avalon slave select / active-low write strobe
//     writedata[31:0]       write data
//     in_port[WIDTH-1:0]    raw asynchronous inputs (buttons / switches)
//     readdata[31:0]        registered read data, one clock latency
//     irq                   registered |(edgecapture & irqmask)
// ---------------------------------------------------------------------------

// Per-bit synchroniser + debouncer. o_rise/o_fall are combinational and high
// during the cycle whose closing edge flips o_stable.
module final_nios_pio_in_debounced_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   w_sync;
    logic                   w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    // The mismatch has now persisted for DEBOUNCE_CYCLES consecutive samples.
    assign w_accept = (w_sync != r_stable) && (r_cnt == CNT_MAX);
    assign o_rise   = w_accept &  w_sync;
    assign o_fall   = w_accept & ~w_sync;
    assign o_stable = r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module final_nios_pio_in_debounced #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rdmux;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_ec;
    logic             w_unused_wd;

    // Only the low WIDTH bits of writedata carry register content.
    assign w_unused_wd = ^writedata;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        final_nios_pio_in_debounced_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .i_in    (in_port[b]),
            .o_stable(w_stable[b]),
            .o_rise  (w_rise[b]),
            .o_fall  (w_fall[b])
        );
    end

    assign w_set = (EDGE_TYPE == 0) ? w_rise :
                   (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);

    assign w_wr  = chipselect && !write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rdmux = '0;
        case (address)
            2'd0:    w_rdmux = 32'(w_stable);
            2'd2:    w_rdmux = 32'(r_mask);
            2'd3:    w_rdmux = 32'(r_ec);
            default: w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= '0;
            r_ec     <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (w_wr && address == 2'd2)
                r_mask <= writedata[WIDTH-1:0];
            // A capture landing on the same edge as its W1C survives.
            r_ec     <= (r_ec & ~w_clr) | w_set;
            irq      <= |(r_ec & r_mask);
            readdata <= w_rdmux;
        end
    end
endmodule

// File: tb/tb_final_nios_pio_in_debounced.sv
module tb_final_nios_pio_in_debounced;
    localparam int W = 3;
    localparam int S = 2;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [W-1:0]     in_port = '0;
    logic [2:0][31:0] rd_o;
    logic [2:0]       irq_o;

    always #5 clk = ~clk;

    // One instance per edge type, all sharing the same stimulus.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        final_nios_pio_in_debounced #(
            .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(k)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_port),
            .readdata  (rd_o[k]),
            .irq       (irq_o[k])
        );
    end

    typedef struct packed {
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: input samples reach the debouncer S edges late; a bit's
    // accepted level flips once D consecutive delayed samples disagree with it.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stab;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_ec[3];
    int           run[W];

    always @(posedge clk) begin : model
        exp_t         e;
        logic [W-1:0] pre;
        logic [W-1:0] clr;
        logic [W-1:0] set[3];
        e = '0;
        if (!reset_n) begin
            m_stab = '0;
            m_mask = '0;
            for (int k = 0; k < 3; k++) m_ec[k] = '0;
            for (int b = 0; b < W; b++) run[b] = 0;
            hist.delete();
            repeat (S) hist.push_back('0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                case (address)
                    2'd0:    e.rd[k] = 32'(m_stab);
                    2'd2:    e.rd[k] = 32'(m_mask);
                    2'd3:    e.rd[k] = 32'(m_ec[k]);
                    default: e.rd[k] = 32'd0;
                endcase
                e.irq[k] = |(m_ec[k] & m_mask);
                set[k]   = '0;
            end
            pre = hist.pop_front();
            hist.push_back(in_port);
            for (int b = 0; b < W; b++) begin
                if (pre[b] != m_stab[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        run[b]    = 0;
                        m_stab[b] = pre[b];
                        if (pre[b])  begin set[0][b] = 1'b1; set[2][b] = 1'b1; end
                        if (!pre[b]) begin set[1][b] = 1'b1; set[2][b] = 1'b1; end
                    end
                end else begin
                    run[b] = 0;
                end
            end
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            for (int k = 0; k < 3; k++) m_ec[k] = (m_ec[k] & ~clr) | set[k];
        end
        exp_q.push_back(e);
    end

    // Monitor: readdata/irq are valid every cycle; compare on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (rd_o[k] !== e.rd[k]) begin
                    n_bad++;
                    $display("FAIL readdata[et%0d] t=%0t addr=%0d got=%h exp=%h",
                             k, $time, address, rd_o[k], e.rd[k]);
                end
                n_cmp++;
                if (irq_o[k] !== e.irq[k]) begin
                    n_bad++;
                    $display("FAIL irq[et%0d] t=%0t got=%b exp=%b", k, $time, irq_o[k], e.irq[k]);
                end
            end
        end
    end

    task automatic tick(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] d);
        @(negedge clk); #1;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = d;
    endtask

    initial begin
        // Reset with reads of every address, then writes to read-only words.
        for (int a = 0; a < 4; a++) tick(2'(a), 1'b0, 1'b1, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) tick(2'(a), 1'b0, 1'b1, 32'd0);
        tick(2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tick(2'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tick(2'd1, 1'b0, 1'b1, 32'd0);
        tick(2'd0, 1'b0, 1'b1, 32'd0);

        // Mask bit0, press bit0 and watch stable/edgecapture/irq.
        tick(2'd2, 1'b1, 1'b0, 32'h1);
        in_port[0] = 1'b1;
        for (int i = 0; i < 10; i++) tick(2'(i % 2 ? 3 : 0), 1'b0, 1'b1, 32'd0);

        // Three-cycle glitch on bit1 must be discarded.
        in_port[1] = 1'b1;
        repeat (3) tick(2'd0, 1'b0, 1'b1, 32'd0);
        in_port[1] = 1'b0;
        for (int i = 0; i < 8; i++) tick(2'(i % 2 ? 3 : 0), 1'b0, 1'b1, 32'd0);

        // W1C bit0, then bit2 press with only bit0 masked.
        tick(2'd3, 1'b1, 1'b0, 32'h1);
        repeat (3) tick(2'd3, 1'b0, 1'b1, 32'd0);
        in_port[2] = 1'b1;
        repeat (10) tick(2'd3, 1'b0, 1'b1, 32'd0);

        // Continuous W1C while bit0 releases and re-presses: capture beats clear.
        in_port[0] = 1'b0;
        repeat (10) tick(2'd3, 1'b1, 1'b0, 32'h1);
        in_port[0] = 1'b1;
        repeat (10) tick(2'd3, 1'b1, 1'b0, 32'h7);
        repeat (4) tick(2'd3, 1'b0, 1'b1, 32'd0);

        // Random inputs, bus traffic and one reset while inputs are high.
        for (int c = 0; c < 3000; c++) begin
            tick(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            if (c == 1500) begin in_port = '1; reset_n = 1'b0; end
            if (c == 1503) reset_n = 1'b1;
        end

        in_port = '0;
        for (int i = 0; i < 12; i++) tick(2'(i % 4), 1'b0, 1'b1, 32'd0);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
